// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with load handshake, shift stall,
// selectable bit order and gapless back-to-back frames.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
  input  logic             shift_en,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             last, accept, advance;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // sreg holds only the bits not yet presented; sout holds the current one.
  function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last      = (state == SHIFT) && (cnt == '0);
    done      = last && shift_en;
    ready     = (state == IDLE) || done;
    accept    = load && ready;
    advance   = (state == SHIFT) && shift_en && !last;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (done && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
      sout <= 1'b0;
    end else if (accept) begin
      sreg <= tail(pdata);
      sout <= head_bit(pdata);
      cnt  <= CNT_LAST;
    end else if (advance) begin
      sreg <= tail(sreg);
      sout <= head_bit(sreg);
      cnt  <= cnt - CW'(1);
    end else if (done) begin
      sout <= 1'b0;
    end
  end

  assign busy       = (state == SHIFT);
  assign sout_valid = (state == SHIFT);

endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
Parametrised parallel-in serial-out shift register with load handshake, shift-enable stall, selectable bit order and back-to-back frame support. It accepts a WIDTH-bit word on a load strobe and presents it one bit per enabled clock on a serial output with a valid qualifier. It sits between parallel datapath logic and any serial link or serial consumer, replacing the fixed 3-bit loader.

Parameters:
WIDTH, 8, bits per frame; legal range 2 to 32.
LSB_FIRST, 0, 0 shifts MSB first; 1 shifts LSB first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
load  input  1  load request; a frame is accepted on an edge where load && ready.
pdata  input  WIDTH  parallel word; captured on the accepting edge.
shift_en  input  1  consumer advance; when 0 in SHIFT, the current bit is held.
ready  output  1  combinational; high when a load will be accepted this cycle.
sout  output  1  serial data bit, registered.
sout_valid  output  1  high while sout carries a frame bit, registered.
busy  output  1  high in SHIFT state, registered.
done  output  1  combinational; high in the cycle the last bit is consumed (last bit presented && shift_en).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, busy=0. Hence ready=1 and done=0. Reset overrides load and shift_en, and aborts any frame in progress without a done pulse.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - ready=1, sout=0, sout_valid=0.
  - load=1 at an edge: capture pdata, go to SHIFT, counter=WIDTH-1.
  - From the next cycle: sout = first bit (pdata[WIDTH-1] if LSB_FIRST=0, else pdata[0]), sout_valid=1, busy=1.
  - Latency from the load edge to the first valid bit is 1 cycle.
- SHIFT:
  - Each edge with shift_en=1 advances to the next bit and decrements the counter.
  - Each edge with shift_en=0 holds sout, the counter and the shift register unchanged. sout_valid stays 1.
  - The last bit is presented when counter==0.
  - On the last-bit cycle with shift_en=1: done=1 and ready=1.
    - If load=1 on that edge: capture the new pdata and stay in SHIFT with counter=WIDTH-1. The next frame's first bit appears the following cycle with no idle gap.
    - Otherwise go to IDLE: sout=0, sout_valid=0, busy=0.
  - load when ready=0 (mid-frame, or last bit while shift_en=0) is ignored, with no side effects.
- pdata is ignored except on accepting edges. Changing pdata mid-frame does not affect the frame.
- Every frame yields exactly WIDTH enabled bit cycles and exactly one done pulse, unless it is aborted by rst.
- The counter is $clog2(WIDTH) bits wide and never wraps below 0.

Test Plan:
1. Reset and idle: hold rst=1 for 2 cycles with load=1 -> sout=0, sout_valid=0, busy=0, ready=1, done=0 throughout. No frame is accepted.
2. MSB-first (WIDTH=4, LSB_FIRST=0):
   - Stimulus: load pdata=4'b1010 for one cycle, shift_en=1.
   - Response: sout=1,0,1,0 on the 4 cycles after the load edge, with sout_valid=1 on those cycles. done=1 only on the 4th. Return to IDLE on the next cycle.
3. LSB-first (WIDTH=4, LSB_FIRST=1), pdata=4'b1101 -> sout=1,0,1,1.
   Default WIDTH=8, MSB-first, pdata=8'hA5 -> sout=1,0,1,0,0,1,0,1.
4. Stall: WIDTH=4, pdata=4'b1010, shift_en=0 for 3 cycles while bit 2 (value 1) is presented.
   - sout must hold 1 and sout_valid stay 1 during the stall, with no done.
   - Total time to done is 4+3 cycles after the first bit.
   - A load pulse during the stall is ignored.
5. Back-to-back: WIDTH=4, frame 4'b1010, then assert load with pdata=4'b0110 on the done cycle.
   - Required sout stream: 1,0,1,0,0,1,1,0 with sout_valid continuously 1 and busy continuously 1.
   - done pulses on the 4th and 8th bits.
6. Reset mid-frame: WIDTH=8, pdata=8'hFF, assert rst on the 3rd bit.
   - The next cycle has sout=0, sout_valid=0, busy=0, ready=1, with no done pulse.
   - A subsequent load of 8'h81 serialises cleanly as 1,0,0,0,0,0,0,1.
